// File: rtl/ro_sample_accumulator.sv
// Ring-oscillator frequency meter: counts synchronised RO rising edges over fixed clk gate
// windows, sums NUM_SAMPLES windows, and serves the held result to the UART byte by byte.
module ro_sample_accumulator #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int NUM_SAMPLES   = 16,
  parameter int CNT_W         = 16,
  parameter int SUM_W         = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ro_in,
  input  logic             sum_en,
  input  logic [1:0]       send_sel,
  output logic             sum_ready,
  output logic [SUM_W-1:0] sum,
  output logic [7:0]       tx_data,
  output logic             busy
);

  localparam int GATE_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int IDX_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(WINDOW_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [SUM_W-1:0]  SUM_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              ro_meta_q, ro_sync_q, ro_prev_q;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  sample_idx_q, sample_idx_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              sum_ready_q, sum_ready_d;
  logic              busy_q, busy_d;

  logic              ro_edge;
  logic [SUM_W:0]    acc_ext;
  logic [SUM_W-1:0]  acc_sat;

  // Synchronised RO level vs. its previous value; one-cycle pulse per rising edge.
  assign ro_edge = ro_sync_q & ~ro_prev_q;

  // One extra bit catches overflow so the accumulator clamps instead of wrapping.
  assign acc_ext = {1'b0, acc_q} + (SUM_W + 1)'(edge_cnt_q);
  assign acc_sat = acc_ext[SUM_W] ? SUM_MAX : acc_ext[SUM_W-1:0];

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    acc_d        = acc_q;
    sample_idx_d = sample_idx_q;
    sum_d        = sum_q;
    sum_ready_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sum_en) begin
          state_d      = GATE;
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          acc_d        = '0;
          sample_idx_d = '0;
        end
      end
      GATE: begin
        if (!sum_en) begin
          state_d = IDLE;
        end else begin
          if (ro_edge && (edge_cnt_q != CNT_MAX)) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
          end
          if (gate_cnt_q == GATE_LAST) begin
            gate_cnt_d = '0;
            state_d    = ADD;
          end else begin
            gate_cnt_d = gate_cnt_q + 1'b1;
          end
        end
      end
      ADD: begin
        // Edges arriving in this cycle are deliberately dropped (dead time between windows).
        if (!sum_en) begin
          state_d = IDLE;
        end else begin
          acc_d      = acc_sat;
          edge_cnt_d = '0;
          if (sample_idx_q == IDX_LAST) begin
            state_d     = DONE;
            sum_d       = acc_sat;
            sum_ready_d = 1'b1;
          end else begin
            sample_idx_d = sample_idx_q + 1'b1;
            state_d      = GATE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      ro_meta_q    <= 1'b0;
      ro_sync_q    <= 1'b0;
      ro_prev_q    <= 1'b0;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      acc_q        <= '0;
      sample_idx_q <= '0;
      sum_q        <= '0;
      sum_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ro_meta_q    <= ro_in;
      ro_sync_q    <= ro_meta_q;
      ro_prev_q    <= ro_sync_q;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      acc_q        <= acc_d;
      sample_idx_q <= sample_idx_d;
      sum_q        <= sum_d;
      sum_ready_q  <= sum_ready_d;
      busy_q       <= busy_d;
    end
  end

  // Byte mux reads only the held result, so bytes stay stable across a multi-byte UART send.
  always_comb begin
    tx_data = 8'h00;
    unique case (send_sel)
      2'd0:    tx_data = sum_q[23:16];
      2'd1:    tx_data = sum_q[15:8];
      2'd2:    tx_data = sum_q[7:0];
      default: tx_data = 8'h00;
    endcase
  end

  assign sum_ready = sum_ready_q;
  assign sum       = sum_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ro_sample_accumulator.sv
// Scoreboarded bench for ro_sample_accumulator: a full-width instance and a CNT_W=2 instance
// share stimulus; expected results are queued at stimulus time and popped on each sum_ready.
module tb_ro_sample_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       ro_in = 1'b0;
  logic       sum_en;
  logic [1:0] send_sel;
  int         ro_mode = 2;  // 0: static low, 1: static high, 2: toggle every clk

  logic        a_sum_ready, b_sum_ready;
  logic [23:0] a_sum, b_sum;
  logic [7:0]  a_tx, b_tx;
  logic        a_busy, b_busy;

  ro_sample_accumulator #(
    .WINDOW_CYCLES(10), .NUM_SAMPLES(4), .CNT_W(16), .SUM_W(24)
  ) dut_a (
    .clk(clk), .reset(reset), .ro_in(ro_in), .sum_en(sum_en), .send_sel(send_sel),
    .sum_ready(a_sum_ready), .sum(a_sum), .tx_data(a_tx), .busy(a_busy)
  );

  ro_sample_accumulator #(
    .WINDOW_CYCLES(10), .NUM_SAMPLES(4), .CNT_W(2), .SUM_W(24)
  ) dut_b (
    .clk(clk), .reset(reset), .ro_in(ro_in), .sum_en(sum_en), .send_sel(send_sel),
    .sum_ready(b_sum_ready), .sum(b_sum), .tx_data(b_tx), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ro_mode)
      0:       ro_in = 1'b0;
      1:       ro_in = 1'b1;
      default: ro_in = ~ro_in;
    endcase
  end

  typedef struct {
    logic [23:0] sum;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Monitor: every sum_ready pulse must match the oldest queued expectation in value and cycle.
  always @(negedge clk) begin
    if (a_sum_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse_a at cycle %0d: sum_ready=1, expected 0", cyc);
      end else begin
        e_a = q_a.pop_front();
        check("sum_a", a_sum, e_a.sum);
        check("pulse_cycle_a", cyc, e_a.cyc);
        check("busy_in_done_a", a_busy, 1);
      end
    end
    if (b_sum_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse_b at cycle %0d: sum_ready=1, expected 0", cyc);
      end else begin
        e_b = q_b.pop_front();
        check("sum_b", b_sum, e_b.sum);
        check("pulse_cycle_b", cyc, e_b.cyc);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_runs(input int first_cyc, input int runs,
                             input logic [23:0] sa, input logic [23:0] sb);
    for (int k = 0; k < runs; k++) begin
      q_a.push_back('{sum: sa, cyc: first_cyc + 46 * k});
      q_b.push_back('{sum: sb, cyc: first_cyc + 46 * k});
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (q_a.size() != 0 || q_b.size() != 0); i++) tick();
    if (q_a.size() != 0 || q_b.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout at cycle %0d: %0d/%0d results outstanding, expected 0",
               cyc, q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_sum_a"}, a_sum, 0);
    check({tag, "_ready_a"}, a_sum_ready, 0);
    check({tag, "_busy_a"}, a_busy, 0);
    check({tag, "_tx_a"}, a_tx, 0);
    check({tag, "_sum_b"}, b_sum, 0);
    check({tag, "_busy_b"}, b_busy, 0);
  endtask

  logic [7:0] tx_exp_a [4] = '{8'h00, 8'h00, 8'h14, 8'h00};
  logic [7:0] tx_exp_b [4] = '{8'h00, 8'h00, 8'h0C, 8'h00};

  initial begin
    reset    = 1'b1;
    sum_en   = 1'b0;
    send_sel = 2'd0;
    tick(3);
    check_idle_zero("reset");
    reset = 1'b0;
    tick(5);

    // Nominal run: 5 edges/window * 4 = 0x14; CNT_W=2 clamps each window at 3 -> 0x0C.
    sum_en = 1'b1;
    expect_runs(cyc + 45, 1, 24'h000014, 24'h00000C);
    drain(60);
    check("busy_after_a", a_busy, 0);
    check("busy_after_b", b_busy, 0);
    sum_en = 1'b0;
    tick(2);
    check("busy_idle_a", a_busy, 0);

    // Byte select, then confirm the bytes hold while idle.
    for (int s = 0; s < 4; s++) begin
      send_sel = 2'(s);
      #1;
      check("tx_sel_a", a_tx, tx_exp_a[s]);
      check("tx_sel_b", b_tx, tx_exp_b[s]);
    end
    tick(10);
    send_sel = 2'd2;
    #1;
    check("tx_held_a", a_tx, 8'h14);
    check("tx_held_b", b_tx, 8'h0C);

    // Abort at cycle 20: back to idle, no pulse, prior result kept; re-run gives fresh result.
    sum_en = 1'b1;
    tick(20);
    sum_en = 1'b0;
    tick(1);
    check("abort_busy_a", a_busy, 0);
    check("abort_busy_b", b_busy, 0);
    tick(50);
    check("abort_sum_kept_a", a_sum, 24'h000014);
    check("abort_sum_kept_b", b_sum, 24'h00000C);
    sum_en = 1'b1;
    expect_runs(cyc + 45, 1, 24'h000014, 24'h00000C);
    drain(60);
    sum_en = 1'b0;
    tick(3);

    // Synchronous reset in the middle of a gate window wipes the held result.
    sum_en = 1'b1;
    tick(5);
    check("pre_reset_busy_a", a_busy, 1);
    sum_en = 1'b0;
    reset  = 1'b1;
    tick(1);
    check_idle_zero("midreset");
    reset = 1'b0;
    tick(3);

    // Static RO low, sum_en held: zero results every 46 cycles.
    ro_mode = 0;
    tick(6);
    sum_en = 1'b1;
    expect_runs(cyc + 45, 3, 24'h0, 24'h0);
    drain(200);
    sum_en = 1'b0;
    tick(3);

    // Static RO high: no rising edges either.
    ro_mode = 1;
    tick(6);
    sum_en = 1'b1;
    expect_runs(cyc + 45, 2, 24'h0, 24'h0);
    drain(150);
    sum_en = 1'b0;
    tick(3);

    // Toggling again: result must climb back from zero.
    ro_mode = 2;
    tick(6);
    sum_en = 1'b1;
    expect_runs(cyc + 45, 1, 24'h000014, 24'h00000C);
    drain(60);
    sum_en = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: simulation did not finish, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
